uart_tx_block: RTL

- UART transmit block; the transmit-side counterpart to the existing receive block. Same frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- A one-byte holding buffer decouples the host write from the shifter, so the host can queue the next byte while the current frame is on the wire.
- Drives the serial line directly; idles high.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_block_if.sv | 23 ++
 rtl/tx_data_buff.sv | 60 ++++++
 rtl/uart_tx_block.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and transmit state type
package uart_pkg;

    localparam int   DATA_BITS     = 8;
    localparam logic START_BIT_VAL = 1'b0;
    localparam logic STOP_BIT_VAL  = 1'b1;
    localparam logic IDLE_LINE_VAL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_block_if.sv
// rtl/uart_tx_block_if.sv - host-side signal bundle of the UART transmitter
interface uart_tx_block_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 data_write;
    logic                 error_clear;
    logic                 serial_out;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 overrun_error;

    modport master (
        output tx_data, data_write, error_clear,
        input  serial_out, tx_ready, tx_busy, overrun_error
    );

    modport slave (
        input  tx_data, data_write, error_clear,
        output serial_out, tx_ready, tx_busy, overrun_error
    );

endinterface

// File: rtl/tx_data_buff.sv
// rtl/tx_data_buff.sv - one-byte holding buffer with sticky overrun flag
module tx_data_buff
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_write,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 error_clear,
    input  logic                 xfer,
    output logic [DATA_BITS-1:0] buf_data,
    output logic                 buf_full,
    output logic                 overrun_error
);

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 full_q, full_d;
    logic                 ovr_q, ovr_d;

    // A transfer empties the buffer on the same edge, so a coincident write lands cleanly.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        ovr_d  = ovr_q;
        if (error_clear) begin
            ovr_d = 1'b0;
        end
        if (xfer) begin
            full_d = data_write;
            if (data_write) begin
                data_d = tx_data;
            end
        end else if (data_write) begin
            if (full_q) begin
                ovr_d = 1'b1;
            end else begin
                data_d = tx_data;
                full_d = 1'b1;
            end
        end
    end

    // Buffer registers; reset leaves the buffer empty and the flag clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
            ovr_q  <= ovr_d;
        end
    end

    assign buf_data      = data_q;
    assign buf_full      = full_q;
    assign overrun_error = ovr_q;

endmodule

// File: rtl/uart_tx_block.sv
// rtl/uart_tx_block.sv - UART transmitter: 8N1 framing, bit timer, shifter
module uart_tx_block
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_block_if.slave  bus
);

    localparam int              TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   TIMER_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shifter_q, shifter_d;
    logic                 serial_q, serial_d;
    logic                 bit_end;
    logic                 xfer;
    logic [DATA_BITS-1:0] buf_data;
    logic                 buf_full;

    tx_data_buff u_buff (
        .clk           (clk),
        .rst           (rst),
        .data_write    (bus.data_write),
        .tx_data       (bus.tx_data),
        .error_clear   (bus.error_clear),
        .xfer          (xfer),
        .buf_data      (buf_data),
        .buf_full      (buf_full),
        .overrun_error (bus.overrun_error)
    );

    assign bit_end = (timer_q == TIMER_MAX);

    // Next-state logic; the line value is computed one edge ahead so serial_out stays registered.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shifter_d = shifter_q;
        serial_d  = serial_q;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d  = '0;
                serial_d = IDLE_LINE_VAL;
                if (buf_full) begin
                    xfer      = 1'b1;
                    shifter_d = buf_data;
                    bit_idx_d = '0;
                    state_d   = START;
                    serial_d  = START_BIT_VAL;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d  = '0;
                    state_d  = DATA;
                    serial_d = shifter_q[0];
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d  = STOP;
                        serial_d = STOP_BIT_VAL;
                    end else begin
                        shifter_d = shifter_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        serial_d  = shifter_q[1];
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (buf_full) begin
                        // Chain straight into the next frame with no idle bit.
                        xfer      = 1'b1;
                        shifter_d = buf_data;
                        bit_idx_d = '0;
                        state_d   = START;
                        serial_d  = START_BIT_VAL;
                    end else begin
                        state_d  = IDLE;
                        serial_d = IDLE_LINE_VAL;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                timer_d  = '0;
                serial_d = IDLE_LINE_VAL;
            end
        endcase
    end

    // State, timer, shifter and line registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shifter_q <= '0;
            serial_q  <= IDLE_LINE_VAL;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shifter_q <= shifter_d;
            serial_q  <= serial_d;
        end
    end

    assign bus.serial_out = serial_q;
    assign bus.tx_busy    = (state_q != IDLE);
    assign bus.tx_ready   = !buf_full;

endmodule
